// File: rtl/udp_encoder_param.sv
// UDP encoder with parametrised bus width. The payload is buffered while the
// RFC 768 checksum is accumulated. The 8-byte UDP header and then the buffered
// payload are streamed out on a valid/ready interface.
module udp_encoder_param #(
    parameter int DATA_W    = 32,
    parameter int MAX_BYTES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       src_ip,
    input  logic [31:0]       dest_ip,
    input  logic [15:0]       src_port,
    input  logic [15:0]       dest_port,
    input  logic [15:0]       len_in,
    input  logic              no_chksum,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    input  logic              data_av,
    output logic              data_rdy,
    output logic [DATA_W-1:0] pkg_data,
    output logic              wr_en,
    input  logic              out_ready,
    output logic              fin,
    output logic              err,
    output logic [15:0]       checksum_out,
    output logic [15:0]       len_out
);
    localparam int BYTES_W   = DATA_W / 8;
    localparam int HALVES    = DATA_W / 16;
    localparam int DEPTH     = MAX_BYTES / BYTES_W;
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BSH       = $clog2(BYTES_W);
    localparam int HDR_WORDS = 64 / DATA_W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        FOLD = 3'd2,
        HDR  = 3'd3,
        PAY  = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [15:0]       src_port_r, dest_port_r, len_r, n_words_r;
    logic [15:0]       in_cnt_r, byte_off_r, out_cnt_r;
    logic              no_chksum_r, last_r;
    logic [31:0]       acc_r;

    logic [15:0]       rem_s, len_plus_s, fold2_s, cs_raw_s, cs_fin_s, total_s;
    logic [16:0]       nw_tmp_s, fold1_s;
    logic [DATA_W-1:0] masked_s, hdr_word_s, out_word_s;
    logic [31:0]       word_sum_s, seed_s;
    logic [63:0]       hdr_all_s;
    logic              in_xfer_s, load_s, fin_s;

    // Input-side datapath: tail masking, per-word sum, header seed and checksum fold.
    always_comb begin
        rem_s    = len_r - byte_off_r;
        masked_s = {DATA_W{1'b0}};
        for (int b = 0; b < BYTES_W; b++) begin
            if (16'(b) < rem_s) begin
                masked_s[DATA_W-1-8*b -: 8] = data[DATA_W-1-8*b -: 8];
            end else begin
                masked_s[DATA_W-1-8*b -: 8] = 8'd0;
            end
        end
        word_sum_s = 32'd0;
        for (int h = 0; h < HALVES; h++) begin
            word_sum_s = word_sum_s + {16'd0, masked_s[DATA_W-1-16*h -: 16]};
        end
        len_plus_s = len_in + 16'd8;
        seed_s = {16'd0, src_ip[31:16]} + {16'd0, src_ip[15:0]}
               + {16'd0, dest_ip[31:16]} + {16'd0, dest_ip[15:0]}
               + 32'h0000_0011 + {16'd0, len_plus_s} + {16'd0, src_port}
               + {16'd0, dest_port} + {16'd0, len_plus_s};
        nw_tmp_s = {1'b0, len_in} + 17'(BYTES_W - 1);
        // Two end-around folds always settle a 32-bit sum into 16 bits.
        fold1_s  = {1'b0, acc_r[31:16]} + {1'b0, acc_r[15:0]};
        fold2_s  = fold1_s[15:0] + {15'd0, fold1_s[16]};
        cs_raw_s = ~fold2_s;
        if (no_chksum_r) begin
            cs_fin_s = 16'h0000;
        end else if (cs_raw_s == 16'h0000) begin
            cs_fin_s = 16'hFFFF;
        end else begin
            cs_fin_s = cs_raw_s;
        end
    end

    // Output word selection, handshakes and next-state logic.
    always_comb begin
        in_xfer_s  = data_rdy & data_av;
        total_s    = n_words_r + 16'(HDR_WORDS);
        load_s     = ((state_r == HDR) || (state_r == PAY)) && (!wr_en || out_ready)
                     && (out_cnt_r < total_s);
        fin_s      = wr_en & out_ready & last_r;
        hdr_all_s  = {src_port_r, dest_port_r, len_out, checksum_out};
        hdr_word_s = (out_cnt_r == 16'd0) ? hdr_all_s[63:64-DATA_W] : hdr_all_s[DATA_W-1:0];
        if (out_cnt_r < 16'(HDR_WORDS)) begin
            out_word_s = hdr_word_s;
        end else begin
            out_word_s = mem[PTR_W'(out_cnt_r - 16'(HDR_WORDS))];
        end
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && (len_in <= 16'(MAX_BYTES))) begin
                    state_s = (len_in == 16'd0) ? FOLD : LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (in_xfer_s && ((in_cnt_r + 16'd1) == n_words_r)) begin
                    state_s = FOLD;
                end else begin
                    state_s = LOAD;
                end
            end
            FOLD: state_s = HDR;
            HDR: begin
                if (fin_s) begin
                    state_s = IDLE;
                end else if (load_s && (out_cnt_r == 16'(HDR_WORDS - 1)) && (n_words_r != 16'd0)) begin
                    state_s = PAY;
                end else begin
                    state_s = HDR;
                end
            end
            PAY: begin
                if (fin_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = PAY;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    assign fin = fin_s;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Payload buffer write port; contents need no reset.
    always_ff @(posedge clk) begin
        if ((state_r == LOAD) && in_xfer_s) begin
            mem[PTR_W'(in_cnt_r)] <= masked_s;
        end
    end

    // Field capture, accumulation, checksum result and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_rdy     <= 1'b0;
            pkg_data     <= {DATA_W{1'b0}};
            wr_en        <= 1'b0;
            err          <= 1'b0;
            checksum_out <= 16'd0;
            len_out      <= 16'd0;
            src_port_r   <= 16'd0;
            dest_port_r  <= 16'd0;
            len_r        <= 16'd0;
            n_words_r    <= 16'd0;
            in_cnt_r     <= 16'd0;
            byte_off_r   <= 16'd0;
            out_cnt_r    <= 16'd0;
            no_chksum_r  <= 1'b0;
            last_r       <= 1'b0;
            acc_r        <= 32'd0;
        end else begin
            err      <= 1'b0;
            data_rdy <= (state_s == LOAD);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (len_in > 16'(MAX_BYTES)) begin
                            err <= 1'b1;
                        end else begin
                            src_port_r  <= src_port;
                            dest_port_r <= dest_port;
                            len_r       <= len_in;
                            no_chksum_r <= no_chksum;
                            len_out     <= len_plus_s;
                            acc_r       <= seed_s;
                            n_words_r   <= 16'(nw_tmp_s >> BSH);
                            in_cnt_r    <= 16'd0;
                            byte_off_r  <= 16'd0;
                            out_cnt_r   <= 16'd0;
                        end
                    end
                end
                LOAD: begin
                    if (in_xfer_s) begin
                        acc_r      <= acc_r + word_sum_s;
                        in_cnt_r   <= in_cnt_r + 16'd1;
                        byte_off_r <= byte_off_r + 16'(BYTES_W);
                    end
                end
                FOLD: checksum_out <= cs_fin_s;
                HDR, PAY: begin
                    if (load_s) begin
                        pkg_data  <= out_word_s;
                        wr_en     <= 1'b1;
                        last_r    <= (out_cnt_r == (total_s - 16'd1));
                        out_cnt_r <= out_cnt_r + 16'd1;
                    end else if (wr_en && out_ready) begin
                        wr_en  <= 1'b0;
                        last_r <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule
